// File: rtl/ram_req_ctrl.sv
// -----------------------------------------------------------------------------
// ram_req_ctrl
//
// Request-side controller for a single-port RAM (256x32 by default). It takes
// read/write requests on a valid/ready channel and issues at most one
// registered RAM access per cycle. Read data returning from the RAM is captured
// into an in-order response FIFO, which drains on a valid/ready response
// channel. Saturating counters report how many reads and writes were accepted.
//
// Requests are only accepted while a response slot is guaranteed. Every read
// that is on the RAM bus, waiting for capture, or parked in the FIFO holds one
// credit. This means the FIFO can never overflow.
//
// Optional feature macro: RAM_CTRL_ADDR_CHK_EN
//   When defined, requests with req_addr_i > ADDR_MAX are accepted but never
//   reach the RAM. An illegal read returns 32'hDEAD_BEEF with rsp_err_o=1 in
//   its normal ordered slot. An illegal write is dropped and not counted.
//   When undefined, every request goes to the RAM and rsp_err_o is tied to 0.
//
// Ports:
//   clk_i, rst_n_i            clock (rising edge), async active-low reset
//   req_valid_i/req_ready_o   request handshake
//   req_we_i, req_addr_i,     request type, address and write data
//   req_wdata_i
//   ram_cs_o, ram_we_o,       registered RAM pins
//   ram_addr_o, ram_data_o
//   ram_rdata_i               RAM read data, valid one edge after the read
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_rdata_o, rsp_err_o    response payload at the FIFO head
//   rd_cnt_o, wr_cnt_o        saturating accepted-read / accepted-write counts
// -----------------------------------------------------------------------------
module ram_req_ctrl #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 32,
  parameter int                RSP_DEPTH = 4,
  parameter logic [ADDR_W-1:0] ADDR_MAX  = 8'hFF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              ram_cs_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [15:0]       rd_cnt_o,
  output logic [15:0]       wr_cnt_o
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              accept;
  logic              addr_ok;
  logic              issue;
  logic              push;
  logic              pop;
  logic              rd_s1;
  logic              rd_s2;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W:0]    outstanding;
  logic [DATA_W-1:0] push_data;
  logic [DATA_W-1:0] mem_data [RSP_DEPTH];

  // Credit: reads in either pipeline stage already own a FIFO slot, so the
  // request side only looks at registered state and never at a same-cycle pop.
  assign outstanding = {1'b0, count} + (CNT_W+1)'(rd_s1) + (CNT_W+1)'(rd_s2);
  assign req_ready_o = (outstanding < (CNT_W+1)'(RSP_DEPTH));
  assign accept      = req_valid_i && req_ready_o;
  assign issue       = accept && addr_ok;

  assign push        = rd_s2;
  assign rsp_valid_o = (count != '0);
  assign pop         = rsp_valid_o && rsp_ready_i;
  assign rsp_rdata_o = rsp_valid_o ? mem_data[rd_ptr] : '0;

`ifdef RAM_CTRL_ADDR_CHK_EN
  logic err_s1;
  logic err_s2;
  logic mem_err [RSP_DEPTH];

  assign addr_ok   = (req_addr_i <= ADDR_MAX);
  assign push_data = err_s2 ? DATA_W'(32'hDEAD_BEEF) : ram_rdata_i;
  assign rsp_err_o = rsp_valid_o && mem_err[rd_ptr];

  // An illegal read travels the same two-stage pipeline as a real read
  // so that its error response lands in issue order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_s1 <= 1'b0;
      err_s2 <= 1'b0;
    end else begin
      err_s1 <= accept && !req_we_i && !addr_ok;
      err_s2 <= err_s1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_err[wr_ptr] <= err_s2;
    end
  end
`else
  logic unused_addr_max;

  assign addr_ok         = 1'b1;
  assign push_data       = ram_rdata_i;
  assign rsp_err_o       = 1'b0;
  assign unused_addr_max = ^ADDR_MAX;
`endif

  // RAM pin registers: chip select pulses for one cycle per issued access.
  // Address and data keep their last value while idle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ram_cs_o   <= 1'b0;
      ram_we_o   <= 1'b0;
      ram_addr_o <= '0;
      ram_data_o <= '0;
    end else begin
      ram_cs_o <= issue;
      ram_we_o <= issue && req_we_i;
      if (issue) begin
        ram_addr_o <= req_addr_i;
        ram_data_o <= req_wdata_i;
      end
    end
  end

  // Read tracking: stage 1 covers the cycle the read is on the RAM bus.
  // Stage 2 covers the cycle its data is returning. Reset drops both stages,
  // so no stale read is ever captured.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_s1 <= 1'b0;
      rd_s2 <= 1'b0;
    end else begin
      rd_s1 <= accept && !req_we_i;
      rd_s2 <= rd_s1;
    end
  end

  // FIFO storage has no reset. The head is gated by rsp_valid_o, so stale
  // contents are never visible.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers and occupancy. The pointers wrap naturally because the
  // depth is a power of two. A push and a pop in the same cycle cancel out.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Status counters stop at all-ones instead of wrapping. Illegal reads
  // still count, because they are answered.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_cnt_o <= '0;
      wr_cnt_o <= '0;
    end else begin
      if (accept && !req_we_i && (rd_cnt_o != 16'hFFFF)) begin
        rd_cnt_o <= rd_cnt_o + 16'd1;
      end
      if (issue && req_we_i && (wr_cnt_o != 16'hFFFF)) begin
        wr_cnt_o <= wr_cnt_o + 16'd1;
      end
    end
  end

  // The credit scheme makes a push into a full FIFO unreachable.
  assert property (@(posedge clk_i) disable iff (!rst_n_i)
                   !(push && (count == CNT_W'(RSP_DEPTH))));

endmodule
